// File: rtl/mux8_arb_pkg.sv
// Shared types and constants for the eight-way round-robin mux arbiter.
// The two-state FSM is fully visible through the busy output (busy == S_GRANT).
package mux8_arb_pkg;
   typedef enum logic {S_IDLE, S_GRANT} arb_state_t;
   localparam int NREQ  = 8;
   localparam int SEL_W = 3;
endpackage

// File: rtl/mux8.sv
// Eight-way N-bit datapath multiplexer; word i lives at d[i*N +: N].
module mux8 #(
   parameter int N = 8
) (
   input  logic [8*N-1:0] d,
   input  logic [2:0]     sel,
   output logic [N-1:0]   y
);
   assign y = d[sel*N +: N];
endmodule

// File: rtl/rr_pick8.sv
// Rotating-priority picker: searches ptr, ptr+1, ... ptr+7 (mod 8) for the first set request.
module rr_pick8
   import mux8_arb_pkg::*;
(
   input  logic [NREQ-1:0]  req,
   input  logic [SEL_W-1:0] ptr,
   output logic             any,
   output logic [SEL_W-1:0] winner
);
   logic [SEL_W-1:0] idx;
   logic             found;

   always_comb begin
      any    = |req;
      winner = '0;
      found  = 1'b0;
      idx    = '0;
      for (int k = 0; k < NREQ; k++) begin
         // 3-bit addition wraps naturally past requester 7
         idx = ptr + SEL_W'(k);
         if (!found && req[idx]) begin
            winner = idx;
            found  = 1'b1;
         end
      end
   end
endmodule

// File: rtl/mux8_rr_arbiter.sv
// Round-robin arbiter that owns the select of a shared mux8 and forwards bursts
// from the granted requester through one valid/ready port.
module mux8_rr_arbiter
   import mux8_arb_pkg::*;
#(
   parameter int N         = 8,
   parameter int MAX_BEATS = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   last,
   input  logic [NREQ*N-1:0] data_in,
   input  logic              out_ready,
   output logic              out_valid,
   output logic [N-1:0]      out_data,
   output logic [NREQ-1:0]   grant,
   output logic [SEL_W-1:0]  select,
   output logic              busy
);
   localparam int CNT_W = $clog2(MAX_BEATS + 1);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BEATS - 1);

   arb_state_t       state;
   logic [SEL_W-1:0] ptr;
   logic [CNT_W-1:0] beat_cnt;
   logic             any;
   logic [SEL_W-1:0] winner;
   logic             sel_req;
   logic             sel_last;
   logic             xfer;

   rr_pick8 u_pick (
      .req    (req),
      .ptr    (ptr),
      .any    (any),
      .winner (winner)
   );

   mux8 #(.N(N)) u_mux (
      .d   (data_in),
      .sel (select),
      .y   (out_data)
   );

   assign sel_req  = req[select];
   assign sel_last = last[select];
   assign busy     = (state == S_GRANT);

   // Handshake: a beat moves on any cycle where out_valid && out_ready are both high;
   // out_valid never waits on out_ready, and a reset cycle forwards nothing.
   assign out_valid = busy && sel_req && rst;
   assign xfer      = out_valid && out_ready;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state    <= S_IDLE;
         grant    <= '0;
         select   <= '0;
         ptr      <= '0;
         beat_cnt <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (any) begin
                  grant    <= NREQ'(1) << winner;
                  select   <= winner;
                  beat_cnt <= '0;
                  state    <= S_GRANT;
               end
            end
            S_GRANT: begin
               // Withdrawal, end of burst and the fairness bound all release the same way
               if (!sel_req || (xfer && (sel_last || beat_cnt == LAST_CNT))) begin
                  state    <= S_IDLE;
                  grant    <= '0;
                  ptr      <= select + SEL_W'(1);
                  beat_cnt <= '0;
               end else if (xfer) begin
                  beat_cnt <= beat_cnt + CNT_W'(1);
               end
            end
            default: begin
               state <= S_IDLE;
               grant <= '0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_mux8_rr_arbiter.sv
// Directed bench for mux8_rr_arbiter: dut_a uses MAX_BEATS=16, dut_b MAX_BEATS=4
// for the fairness-bound scenario; both share the stimulus.
module tb_mux8_rr_arbiter;
   localparam int N = 8;

   logic         clk = 1'b0;
   logic         rst;
   logic [7:0]   req;
   logic [7:0]   last;
   logic [8*N-1:0] data_in;
   logic         out_ready;

   logic         out_valid_a, busy_a, out_valid_b, busy_b;
   logic [N-1:0] out_data_a, out_data_b;
   logic [7:0]   grant_a, grant_b;
   logic [2:0]   select_a, select_b;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   mux8_rr_arbiter #(.N(N), .MAX_BEATS(16)) dut_a (
      .clk(clk), .rst(rst), .req(req), .last(last), .data_in(data_in),
      .out_ready(out_ready), .out_valid(out_valid_a), .out_data(out_data_a),
      .grant(grant_a), .select(select_a), .busy(busy_a)
   );

   mux8_rr_arbiter #(.N(N), .MAX_BEATS(4)) dut_b (
      .clk(clk), .rst(rst), .req(req), .last(last), .data_in(data_in),
      .out_ready(out_ready), .out_valid(out_valid_b), .out_data(out_data_b),
      .grant(grant_b), .select(select_b), .busy(busy_b)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_words(input logic [7:0] base);
      for (int i = 0; i < 8; i++) data_in[i*N +: N] = base + 8'(i);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      req = 8'h00;
      last = 8'h00;
      out_ready = 1'b1;
      tick();
      tick();
      rst = 1'b1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      req = 8'hFF;
      last = 8'h00;
      out_ready = 1'b1;
      set_words(8'h50);
      tick();
      tick();
      n_tests++; if (grant_a !== 8'h00) begin n_fail++; $display("FAIL reset_grant got %h exp 00", grant_a); end
      n_tests++; if (select_a !== 3'd0) begin n_fail++; $display("FAIL reset_select got %0d exp 0", select_a); end
      n_tests++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b exp 0", out_valid_a); end
      n_tests++; if (busy_a !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b exp 0", busy_a); end
      n_tests++; if (out_data_a !== 8'h50) begin n_fail++; $display("FAIL reset_data got %h exp 50", out_data_a); end
      rst = 1'b1;
      tick();
      n_tests++; if (grant_a !== 8'h01) begin n_fail++; $display("FAIL reset_first_grant got %h exp 01", grant_a); end
      n_tests++; if (select_a !== 3'd0) begin n_fail++; $display("FAIL reset_first_select got %0d exp 0", select_a); end
   endtask

   task automatic test_rotation();
      logic [7:0] exp_grant [4] = '{8'h02, 8'h08, 8'h40, 8'h02};
      logic [2:0] exp_sel   [4] = '{3'd1, 3'd3, 3'd6, 3'd1};
      do_reset();
      set_words(8'hC0);
      req = 8'h4A;
      last = 8'hFF;
      out_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         tick();
         n_tests++; if (grant_a !== exp_grant[k]) begin n_fail++; $display("FAIL rot_grant[%0d] got %h exp %h", k, grant_a, exp_grant[k]); end
         n_tests++; if (select_a !== exp_sel[k]) begin n_fail++; $display("FAIL rot_select[%0d] got %0d exp %0d", k, select_a, exp_sel[k]); end
         n_tests++; if (out_valid_a !== 1'b1) begin n_fail++; $display("FAIL rot_valid[%0d] got %b exp 1", k, out_valid_a); end
         n_tests++; if (out_data_a !== 8'hC0 + 8'(exp_sel[k])) begin n_fail++; $display("FAIL rot_data[%0d] got %h exp %h", k, out_data_a, 8'hC0 + 8'(exp_sel[k])); end
         tick();
         n_tests++; if (grant_a !== 8'h00 || busy_a !== 1'b0) begin n_fail++; $display("FAIL rot_bubble[%0d] got grant %h busy %b exp 00/0", k, grant_a, busy_a); end
      end
      req = 8'h00;
   endtask

   task automatic test_burst_backpressure();
      int b = 0;
      int xfers = 0;
      do_reset();
      set_words(8'h00);
      req = 8'h20;
      last = 8'h00;
      out_ready = 1'b0;
      tick();
      n_tests++; if (grant_a !== 8'h20) begin n_fail++; $display("FAIL burst_grant got %h exp 20", grant_a); end
      for (int c = 0; c < 20 && b < 4; c++) begin
         out_ready = (c % 2 == 0);
         data_in[5*N +: N] = 8'hA0 + 8'(b);
         last = (b == 3) ? 8'h20 : 8'h00;
         #1;
         n_tests++; if (grant_a !== 8'h20 || out_valid_a !== 1'b1) begin n_fail++; $display("FAIL burst_hold[%0d] got grant %h valid %b exp 20/1", c, grant_a, out_valid_a); end
         n_tests++; if (out_data_a !== 8'hA0 + 8'(b)) begin n_fail++; $display("FAIL burst_data[%0d] got %h exp %h", c, out_data_a, 8'hA0 + 8'(b)); end
         if (out_valid_a && out_ready) xfers++;
         tick();
         if (out_ready) b++;
      end
      n_tests++; if (xfers != 4) begin n_fail++; $display("FAIL burst_count got %0d exp 4", xfers); end
      n_tests++; if (grant_a !== 8'h00 || busy_a !== 1'b0) begin n_fail++; $display("FAIL burst_release got grant %h busy %b exp 00/0", grant_a, busy_a); end
      // ptr should now be 6, so requester 6 beats requester 0
      req = 8'h41;
      last = 8'h00;
      out_ready = 1'b1;
      tick();
      n_tests++; if (grant_a !== 8'h40) begin n_fail++; $display("FAIL burst_ptr got grant %h exp 40", grant_a); end
      req = 8'h00;
   endtask

   task automatic test_forced_release();
      logic [7:0] exp_g [11] = '{8'h04, 8'h04, 8'h04, 8'h04, 8'h00,
                                 8'h80, 8'h80, 8'h80, 8'h80, 8'h00, 8'h04};
      do_reset();
      set_words(8'h30);
      req = 8'h84;
      last = 8'h00;
      out_ready = 1'b1;
      for (int k = 0; k < 11; k++) begin
         tick();
         n_tests++; if (grant_b !== exp_g[k]) begin n_fail++; $display("FAIL forced_grant[%0d] got %h exp %h", k, grant_b, exp_g[k]); end
         n_tests++; if (out_valid_b !== (exp_g[k] != 8'h00)) begin n_fail++; $display("FAIL forced_valid[%0d] got %b exp %b", k, out_valid_b, exp_g[k] != 8'h00); end
      end
      req = 8'h00;
   endtask

   task automatic test_abort_wrap();
      do_reset();
      set_words(8'h70);
      req = 8'h80;
      last = 8'h00;
      out_ready = 1'b1;
      tick();
      n_tests++; if (grant_a !== 8'h80 || select_a !== 3'd7) begin n_fail++; $display("FAIL abort_grant got %h/%0d exp 80/7", grant_a, select_a); end
      tick();
      n_tests++; if (grant_a !== 8'h80) begin n_fail++; $display("FAIL abort_midburst got %h exp 80", grant_a); end
      req = 8'h01;
      #1;
      n_tests++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL abort_valid got %b exp 0", out_valid_a); end
      tick();
      n_tests++; if (grant_a !== 8'h00 || busy_a !== 1'b0) begin n_fail++; $display("FAIL abort_release got %h/%b exp 00/0", grant_a, busy_a); end
      req = 8'h81;
      tick();
      n_tests++; if (grant_a !== 8'h01 || select_a !== 3'd0) begin n_fail++; $display("FAIL abort_wrap got %h/%0d exp 01/0", grant_a, select_a); end
      req = 8'h00;
   endtask

   task automatic test_reset_midburst();
      do_reset();
      set_words(8'h90);
      req = 8'h10;
      last = 8'h10;
      out_ready = 1'b1;
      tick();
      tick();
      last = 8'h00;
      tick();
      n_tests++; if (grant_a !== 8'h10) begin n_fail++; $display("FAIL rmid_grant got %h exp 10", grant_a); end
      tick();
      n_tests++; if (grant_a !== 8'h10 || out_valid_a !== 1'b1) begin n_fail++; $display("FAIL rmid_burst got %h/%b exp 10/1", grant_a, out_valid_a); end
      rst = 1'b0;
      #1;
      n_tests++; if (out_valid_a !== 1'b0) begin n_fail++; $display("FAIL rmid_valid got %b exp 0", out_valid_a); end
      tick();
      n_tests++; if (grant_a !== 8'h00 || busy_a !== 1'b0 || select_a !== 3'd0) begin n_fail++; $display("FAIL rmid_state got %h/%b/%0d exp 00/0/0", grant_a, busy_a, select_a); end
      rst = 1'b1;
      req = 8'h30;
      tick();
      n_tests++; if (grant_a !== 8'h10) begin n_fail++; $display("FAIL rmid_ptr got %h exp 10", grant_a); end
      req = 8'h00;
   endtask

   initial begin
      rst = 1'b0;
      req = 8'h00;
      last = 8'h00;
      out_ready = 1'b0;
      data_in = '0;
      test_reset();
      test_rotation();
      test_burst_backpressure();
      test_forced_release();
      test_abort_wrap();
      test_reset_midburst();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
